// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with flags, valid/ready in and out,
// and a shift-add multiply that takes one iteration per clock.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (a, b, op)
//   out_valid/out_ready result handshake (result, result_hi, flags)
//   carry, zero, ovf    carry/borrow, all-zero, signed overflow
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic             accept;
  logic             is_mul;
  logic             last_iter;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_add;
  logic [WIDTH-1:0] mplier;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] r_nx;
  logic             c_nx;
  logic             v_nx;

  // in_ready is forced low while reset is held
  assign in_ready = rst_n &&
    ((state == S_IDLE) ||
     (state == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == 4'd9);
  assign out_valid = (state == S_DONE);
  assign last_iter = (cnt == LAST);
  assign acc_add   = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = is_mul ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (last_iter) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (accept) begin
          state_nx = is_mul ? S_MUL : S_DONE;
        end else if (out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    addend = b;
    sum    = '0;
    r_nx   = '0;
    c_nx   = 1'b0;
    v_nx   = 1'b0;
    case (op)
      4'd1: begin
        addend = b << 1;
        sum    = {1'b0, a} + {1'b0, addend};
        r_nx   = sum[WIDTH-1:0];
        c_nx   = sum[WIDTH];
      end
      4'd2: begin
        sum  = {1'b0, a} - {1'b0, b};
        r_nx = sum[WIDTH-1:0];
        c_nx = sum[WIDTH];
        v_nx = (a[MSB] != b[MSB]) &&
               (r_nx[MSB] != a[MSB]);
      end
      4'd3: begin
        addend = b >> 1;
        sum    = {1'b0, a} + {1'b0, addend};
        r_nx   = sum[WIDTH-1:0];
        c_nx   = sum[WIDTH];
      end
      4'd4: r_nx = '0;
      4'd5: r_nx = a | b;
      4'd6: r_nx = a & b;
      4'd7: begin
        r_nx = b << 1;
        c_nx = b[MSB];
      end
      4'd8: r_nx = a ^ b;
      4'd9: r_nx = '0;
      default: begin
        sum  = {1'b0, a} + {1'b0, b};
        r_nx = sum[WIDTH-1:0];
        c_nx = sum[WIDTH];
        v_nx = (a[MSB] == b[MSB]) &&
               (r_nx[MSB] != a[MSB]);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      if (accept && is_mul) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt    <= '0;
      end else if (state == S_MUL) begin
        acc    <= acc_add;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last_iter) begin
          result    <= acc_add[WIDTH-1:0];
          result_hi <= acc_add[2*WIDTH-1:WIDTH];
          carry     <= 1'b0;
          ovf       <= 1'b0;
          zero      <= (acc_add == '0);
        end
      end
      // results of a MUL start leave the old outputs untouched
      if (accept && !is_mul) begin
        result    <= r_nx;
        result_hi <= '0;
        carry     <= c_nx;
        ovf       <= v_nx;
        zero      <= (r_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with WIDTH=8,
// directed vectors plus random ops against an arithmetic model.
module tb_alu_seq;

  localparam int W = 8;
  localparam int OW = 2 * W + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .op(op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .result_hi(result_hi),
    .carry(carry),
    .zero(zero),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [OW-1:0] obs_now();
    return {result, result_hi, carry, zero, ovf};
  endfunction

  // Reference: plain integer arithmetic on the op definitions
  function automatic logic [OW-1:0] model(
    input int o, input longint x, input longint y);
    longint m, lo, hi, s, sx, sy, ss;
    bit c, v;
    m = longint'(1) << W;
    hi = 0; c = 0; v = 0; lo = 0;
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    case (o)
      1: begin s = x + (y * 2) % m; lo = s % m; c = s >= m; end
      2: begin
        lo = (x - y + m) % m; c = x < y;
        ss = sx - sy; v = ss > m / 2 - 1 || ss < -(m / 2);
      end
      3: begin s = x + y / 2; lo = s % m; c = s >= m; end
      4: lo = 0;
      5: lo = x | y;
      6: lo = x & y;
      7: begin lo = (y * 2) % m; c = y >= m / 2; end
      8: lo = x ^ y;
      9: begin s = x * y; lo = s % m; hi = s / m; end
      default: begin
        s = x + y; lo = s % m; c = s >= m;
        ss = sx + sy; v = ss > m / 2 - 1 || ss < -(m / 2);
      end
    endcase
    return {lo[W-1:0], hi[W-1:0], c, (lo == 0 && hi == 0), v};
  endfunction

  // Issue one op, return edges from acceptance to out_valid and outputs
  task automatic do_op(input int o, input int x, input int y,
                       output int lat, output logic [OW-1:0] obs,
                       output bit rdy_leak);
    int n;
    @(negedge clk);
    in_valid = 1'b1; op = 4'(o); a = W'(x); b = W'(y);
    out_ready = 1'b0;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    lat = 0; rdy_leak = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_leak = 1;
      @(negedge clk);
      lat++;
    end
    obs = obs_now();
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [OW-1:0] o; bit lk;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, obs_now()} !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0",
               {in_ready, out_valid, obs_now()});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", in_ready);
    end
    do_op(0, 'hF0, 'h20, lat, o, lk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, obs_now()} !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0",
               {in_ready, out_valid, obs_now()});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int ops[10] = '{0, 0, 2, 2, 1, 3, 7, 8, 4, 13};
    int xs[10]  = '{'hF0, 'h7F, 'h05, 'h33, 'h01, 'h10, 'h00, 'hAA,
                    'h5C, 'h02};
    int ys[10]  = '{'h20, 'h01, 'h07, 'h33, 'h81, 'h03, 'h81, 'hFF,
                    'h3D, 'h03};
    // {result, carry, zero, ovf} from the worked examples
    logic [W+2:0] ex[10] = '{{8'h10, 3'b100}, {8'h80, 3'b001},
                             {8'hFE, 3'b100}, {8'h00, 3'b010},
                             {8'h03, 3'b000}, {8'h11, 3'b000},
                             {8'h02, 3'b100}, {8'h55, 3'b000},
                             {8'h00, 3'b010}, {8'h05, 3'b000}};
    int lat; logic [OW-1:0] o; bit lk;
    for (int i = 0; i < 10; i++) begin
      do_op(ops[i], xs[i], ys[i], lat, o, lk);
      checks++;
      if ({o[OW-1:OW-W], o[2:0]} !== ex[i] || lat != 0) begin
        failures++;
        $display("FAIL directed_%0d got=%h lat=%0d exp=%h lat=0",
                 i, {o[OW-1:OW-W], o[2:0]}, lat, ex[i]);
      end
    end
  endtask

  task automatic test_mul();
    int xs[3] = '{'hFF, 'h00, 'h0D};
    int ys[3] = '{'hFF, 'h5A, 'hB7};
    int lat; logic [OW-1:0] o; logic [OW-1:0] e; bit lk;
    for (int i = 0; i < 3; i++) begin
      do_op(9, xs[i], ys[i], lat, o, lk);
      e = model(9, xs[i], ys[i]);
      checks++;
      if (o !== e || lat != W || lk) begin
        failures++;
        $display("FAIL mul_%0d got=%h lat=%0d leak=%0d exp=%h lat=%0d",
                 i, o, lat, lk, e, W);
      end
    end
    checks++;
    if (model(9, 'hFF, 'hFF) !== {8'h01, 8'hFE, 3'b000} ||
        o === 'x) begin
      failures++;
      $display("FAIL mul_ref got=%h exp=01fe0", model(9, 'hFF, 'hFF));
    end
  endtask

  task automatic test_stream();
    int xs[5]; int ys[5]; logic [OW-1:0] e[5];
    for (int i = 0; i < 5; i++) begin
      xs[i] = $urandom_range(0, 255);
      ys[i] = $urandom_range(0, 255);
      e[i] = model(0, xs[i], ys[i]);
    end
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; op = 4'd0;
    a = W'(xs[0]); b = W'(ys[0]);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (!out_valid || obs_now() !== e[i-1]) begin
        failures++;
        $display("FAIL stream_%0d got=%h v=%b exp=%h",
                 i - 1, obs_now(), out_valid, e[i-1]);
      end
      a = W'(xs[i]); b = W'(ys[i]);
      if (i == 4) out_ready = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (!out_valid || in_ready || obs_now() !== e[3]) begin
        failures++;
        $display("FAIL hold_%0d got=%h v=%b r=%b exp=%h",
                 k, obs_now(), out_valid, in_ready, e[3]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (!out_valid || obs_now() !== e[4]) begin
      failures++;
      $display("FAIL stream_pending got=%h v=%b exp=%h",
               obs_now(), out_valid, e[4]);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    int lat; logic [OW-1:0] o; bit lk; bit seen;
    @(negedge clk);
    in_valid = 1'b1; op = 4'd9; a = 8'hC3; b = 8'h7E;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, obs_now()} !== '0) begin
      failures++;
      $display("FAIL mid_mul_reset got=%h exp=0",
               {in_ready, out_valid, obs_now()});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_mul_pulse got=1 exp=0");
    end
    out_ready = 1'b0;
    do_op(0, 1, 1, lat, o, lk);
    checks++;
    if (o !== {8'h02, 8'h00, 3'b000} || lat != 0) begin
      failures++;
      $display("FAIL post_reset_add got=%h lat=%0d exp=02000 lat=0",
               o, lat);
    end
  endtask

  task automatic test_random();
    int lat; logic [OW-1:0] o; logic [OW-1:0] e; bit lk;
    int x; int y; int p;
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 15);
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      do_op(p, x, y, lat, o, lk);
      e = model(p, x, y);
      checks++;
      if (o !== e || lat != ((p == 9) ? W : 0) || lk) begin
        failures++;
        $display("FAIL rand_%0d op=%0d got=%h lat=%0d exp=%h",
                 i, p, o, lat, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_stream();
    test_reset_mid_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 8-bit combinational ALU. It keeps that ALU's operation set and adds SUB, XOR and a multi-cycle unsigned multiply. Outputs are registered and carry status flags. Operands enter and results leave through valid/ready handshakes, so the block sits between an operand-issue stage and a result-writeback stage without combinational paths between them.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 4..32.
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands and op present.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  4  operation select.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  low result word.
- result_hi  output  WIDTH  high product word for MUL; 0 for all other ops.
- carry  output  1  carry/borrow flag.
- zero  output  1  result (and result_hi) all zero.
- ovf  output  1  signed overflow flag.

## Operation
- An operation is accepted on a rising edge where in_valid && in_ready; a, b and op are captured on that edge.
- Arithmetic is unsigned, modulo 2^WIDTH. carry is bit WIDTH of the (WIDTH+1)-bit sum.
- Op encoding:
  - 0 ADD: A+B; carry as above.
  - 1 ADDSL: A+(B<<1), with B<<1 truncated to WIDTH first.
  - 2 SUB: A-B; carry=1 when A<B (borrow).
  - 3 ADDSR: A+(B>>1), logical shift.
  - 4 ZERO: 0.
  - 5 OR: A|B.
  - 6 AND: A&B.
  - 7 SHLB: B<<1; carry=B[WIDTH-1].
  - 8 XOR: A^B.
  - 9 MUL: {result_hi,result}=A*B, full 2*WIDTH product.
  - 10-15: behave exactly as ADD.
- carry=0 for ops 4,5,6,8,9.
- ovf is set only for ADD (and aliases 10-15) and SUB, using the two's-complement rule (operand signs vs. result sign); ovf=0 for all other ops.
- zero=1 iff result==0 and result_hi==0.
- FSM states:
  - IDLE: no result pending.
  - MUL: shift-add multiply in progress.
  - DONE: result pending.
- FSM transitions:
  - IDLE → DONE on accepting a non-MUL op.
  - IDLE → MUL on accepting MUL.
  - MUL → DONE after WIDTH iterations.
  - DONE → IDLE on out_ready when no new op is accepted.
  - DONE → DONE or MUL on out_ready with a new op accepted that cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready); in_ready=0 in MUL and while rst_n is low.
- MUL datapath: one iteration per clock, using the LSB of the multiplier and a 2*WIDTH accumulator. The iteration counter is ceil(log2(WIDTH+1)) bits.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE; out_valid, result, result_hi, carry, zero, ovf all 0. The first acceptance is possible on the first edge after rst_n deasserts.
- Non-MUL latency: out_valid and result are valid in the cycle immediately after the acceptance edge (1 cycle).
- MUL latency: out_valid rises WIDTH cycles after the acceptance edge. The acceptance edge loads operands; iteration edges 1..WIDTH follow; DONE is entered on edge WIDTH. in_ready is 0 throughout.
- Backpressure: while out_valid && !out_ready, result, result_hi and the flags hold stable and in_ready=0.
- Back-to-back: a DONE cycle with out_ready=1 and in_valid=1 both consumes the current result and accepts the next op, giving full throughput of one non-MUL op per cycle.
- Output registers change only on an acceptance edge (non-MUL) or on the MUL→DONE edge. During MUL, the outputs keep the previous values and out_valid=0.
- Reset mid-MUL aborts the operation immediately with no result emitted. in_ready is 1 in the cycle after rst_n deasserts.
- Inputs a, b and op are don't-care when no acceptance occurs.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately, in_ready=0; release -> in_ready=1 the next cycle.
- ADD/SUB flags (WIDTH=8): ADD 0xF0+0x20 -> result 0x10, carry 1, zero 0, ovf 0. ADD 0x7F+0x01 -> 0x80, ovf 1. SUB 0x05-0x07 -> 0xFE, carry 1. SUB 0x33-0x33 -> 0x00, zero 1. All results 1 cycle after acceptance.
- Shift/logic/alias ops: ADDSL 0x01,0x81 -> 0x03. ADDSR 0x10,0x03 -> 0x11. SHLB b=0x81 -> 0x02, carry 1. XOR 0xAA,0xFF -> 0x55. ZERO -> 0x00, zero 1. op 13 with 0x02,0x03 -> 0x05.
- MUL: 0xFF*0xFF -> result_hi 0xFE, result 0x01, out_valid exactly 8 cycles after acceptance, in_ready 0 during those cycles. 0x00*0x5A -> zero 1.
- Backpressure and streaming: 4 ADDs with out_ready=1 -> one result per cycle in order. Then hold out_ready=0 for 3 cycles -> outputs stable, in_ready 0, no op lost.
- Reset during MUL at iteration 4 -> no out_valid pulse; a following ADD 0x01+0x01 -> 0x02 with normal 1-cycle latency.
